pipeline_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
- Keeps a shadow scoreboard of the destination register, write-enable, load flag and valid bit of the instructions in EX, MEM and WB.
- Every cycle it derives the per-stage register enables and flushes from that scoreboard and the EX/MEM status inputs: load-use interlock, taken-branch flush, data-memory wait.
- Sits beside the RAW forwarding logic: forwarding supplies operand values, this block decides whether the pipeline advances.

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/sat_counter.sv | 27 ++
 rtl/pipeline_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, the
// shadow-scoreboard entry layout and the architectural zero register.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wen;
        logic       is_load;
    } sb_entry_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead
// of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] cnt
);

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (&v) ? v : v + W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: tracks EX/MEM/WB in a
// shadow scoreboard and derives per-stage enables and bubble injects.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LU_CYCLES = 1,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_wen,
    input  logic             id_is_load,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             ex_valid,
    output logic             mem_valid,
    output logic             wb_valid,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [2:0] LU_LOAD = 3'(LU_CYCLES - 1);

    state_e     state, state_nxt, ret_state, ret_nxt, eff_state;
    logic [2:0] lu_cnt, lu_cnt_nxt;
    sb_entry_t  sb_p0, sb_p1, sb_p2;
    logic       lu_hit, br_taken, wb_bubble;
    logic       pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
    logic       ifid_flush_c, idex_flush_c;
    logic       unused_wb;

    assign ex_valid  = sb_p0.valid;
    assign mem_valid = sb_p1.valid;
    assign wb_valid  = sb_p2.valid;
    // WB payload is shadowed for debug visibility only.
    assign unused_wb = ^{sb_p2.rd, sb_p2.wen, sb_p2.is_load};

    assign br_taken = ex_branch_taken & sb_p0.valid;
    assign lu_hit   = sb_p0.valid & sb_p0.is_load & sb_p0.wen & (sb_p0.rd != REG_X0)
                    & id_valid & ((id_rs1 == sb_p0.rd) | (id_rs2 == sb_p0.rd));

    // Leaving MEM_WAIT, the same cycle is judged under the saved state.
    assign eff_state = (state == MEM_WAIT) ? ret_state : state;

    always_comb begin
        pc_en_c      = 1'b1;
        ifid_en_c    = 1'b1;
        idex_en_c    = 1'b1;
        exmem_en_c   = 1'b1;
        memwb_en_c   = 1'b1;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        wb_bubble    = 1'b0;
        state_nxt    = eff_state;
        ret_nxt      = ret_state;
        lu_cnt_nxt   = lu_cnt;
        if (mem_busy) begin
            pc_en_c    = 1'b0;
            ifid_en_c  = 1'b0;
            idex_en_c  = 1'b0;
            exmem_en_c = 1'b0;
            wb_bubble  = 1'b1;
            state_nxt  = MEM_WAIT;
            if (state != MEM_WAIT) begin
                ret_nxt = state;
            end
        end else if (br_taken) begin
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
            state_nxt    = RUN;
            lu_cnt_nxt   = '0;
        end else if (eff_state == RUN && lu_hit) begin
            pc_en_c      = 1'b0;
            ifid_en_c    = 1'b0;
            idex_flush_c = 1'b1;
            lu_cnt_nxt   = LU_LOAD;
            state_nxt    = (LU_CYCLES > 1) ? LU_STALL : RUN;
        end else if (eff_state == LU_STALL) begin
            pc_en_c      = 1'b0;
            ifid_en_c    = 1'b0;
            idex_flush_c = 1'b1;
            if (lu_cnt <= 3'd1) begin
                lu_cnt_nxt = '0;
                state_nxt  = RUN;
            end else begin
                lu_cnt_nxt = lu_cnt - 3'd1;
            end
        end else begin
            state_nxt = RUN;
        end
    end

    assign pc_en      = pc_en_c    & ~rst;
    assign ifid_en    = ifid_en_c  & ~rst;
    assign idex_en    = idex_en_c  & ~rst;
    assign exmem_en   = exmem_en_c & ~rst;
    assign memwb_en   = memwb_en_c & ~rst;
    assign ifid_flush = ifid_flush_c | rst;
    assign idex_flush = idex_flush_c | rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            ret_state <= RUN;
            lu_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            lu_cnt    <= lu_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_p0 <= '0;
            sb_p1 <= '0;
            sb_p2 <= '0;
        end else begin
            // ID -> EX
            if (idex_en_c) begin
                sb_p0.valid   <= id_valid & ~idex_flush_c;
                sb_p0.rd      <= id_rd;
                sb_p0.wen     <= id_wen;
                sb_p0.is_load <= id_is_load;
            end
            // EX -> MEM
            if (exmem_en_c) begin
                sb_p1 <= sb_p0;
            end
            // MEM -> WB
            if (memwb_en_c) begin
                sb_p2 <= sb_p1;
                if (wb_bubble) begin
                    sb_p2.valid <= 1'b0;
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~pc_en_c),
        .clear (1'b0),
        .cnt   (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (br_taken & ~mem_busy),
        .clear (1'b0),
        .cnt   (flush_count)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (LU_CYCLES=1/CNT_W=32 and
// LU_CYCLES=3/CNT_W=4) driven in lockstep and compared to a slot-level model.
module tb_pipeline_ctrl;

    typedef struct {
        bit v;
        int rd;
        bit wen;
        bit ld;
    } slot_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_wen, id_is_load, ex_branch_taken, mem_busy;

    logic [1:0]  pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic [1:0]  ifid_flush, idex_flush, ex_valid, mem_valid, wb_valid;
    logic [31:0] stall_a, flush_a;
    logic [3:0]  stall_b, flush_b;

    int checks = 0;
    int errors = 0;

    slot_t  m_ex [2];
    slot_t  m_mem[2];
    slot_t  m_wb [2];
    int     m_left [2];
    longint m_stall[2];
    longint m_flush[2];
    int     lu_tab [2] = '{1, 3};
    longint cap    [2] = '{64'hFFFF_FFFF, 15};

    always #5 clk = ~clk;

    pipeline_ctrl #(.LU_CYCLES(1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_en(pc_en[0]), .ifid_en(ifid_en[0]), .idex_en(idex_en[0]),
        .exmem_en(exmem_en[0]), .memwb_en(memwb_en[0]),
        .ifid_flush(ifid_flush[0]), .idex_flush(idex_flush[0]),
        .ex_valid(ex_valid[0]), .mem_valid(mem_valid[0]), .wb_valid(wb_valid[0]),
        .stall_cycles(stall_a), .flush_count(flush_a)
    );

    pipeline_ctrl #(.LU_CYCLES(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_en(pc_en[1]), .ifid_en(ifid_en[1]), .idex_en(idex_en[1]),
        .exmem_en(exmem_en[1]), .memwb_en(memwb_en[1]),
        .ifid_flush(ifid_flush[1]), .idex_flush(idex_flush[1]),
        .ex_valid(ex_valid[1]), .mem_valid(mem_valid[1]), .wb_valid(wb_valid[1]),
        .stall_cycles(stall_b), .flush_count(flush_b)
    );

    task automatic chk(input string tag, input int inst, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, inst, obs, exp);
        end
    endtask

    function automatic logic [63:0] stall_of(int i);
        return (i == 0) ? 64'(stall_a) : 64'(stall_b);
    endfunction

    function automatic logic [63:0] flush_of(int i);
        return (i == 0) ? 64'(flush_a) : 64'(flush_b);
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            m_ex[i]    = '{0, 0, 0, 0};
            m_mem[i]   = '{0, 0, 0, 0};
            m_wb[i]    = '{0, 0, 0, 0};
            m_left[i]  = 0;
            m_stall[i] = 0;
            m_flush[i] = 0;
        end
    endtask

    function automatic bit hit(int i);
        return m_ex[i].v && m_ex[i].ld && m_ex[i].wen && m_ex[i].rd != 0 && id_valid
            && (int'(id_rs1) == m_ex[i].rd || int'(id_rs2) == m_ex[i].rd);
    endfunction

    // 0: memory wait, 1: taken branch, 2: load-use stall, 3: free flow
    function automatic int mode_of(int i);
        if (mem_busy) return 0;
        if (ex_branch_taken && m_ex[i].v) return 1;
        if (m_left[i] > 0 || hit(i)) return 2;
        return 3;
    endfunction

    task automatic compare(input int i, input int md);
        logic [6:0] e;
        case (md)
            0:       e = 7'b0000100;
            1:       e = 7'b1111111;
            2:       e = 7'b0011101;
            default: e = 7'b1111100;
        endcase
        chk("pc_en",        i, 64'(pc_en[i]),      64'(e[6]));
        chk("ifid_en",      i, 64'(ifid_en[i]),    64'(e[5]));
        chk("idex_en",      i, 64'(idex_en[i]),    64'(e[4]));
        chk("exmem_en",     i, 64'(exmem_en[i]),   64'(e[3]));
        chk("memwb_en",     i, 64'(memwb_en[i]),   64'(e[2]));
        chk("ifid_flush",   i, 64'(ifid_flush[i]), 64'(e[1]));
        chk("idex_flush",   i, 64'(idex_flush[i]), 64'(e[0]));
        chk("ex_valid",     i, 64'(ex_valid[i]),   64'(m_ex[i].v));
        chk("mem_valid",    i, 64'(mem_valid[i]),  64'(m_mem[i].v));
        chk("wb_valid",     i, 64'(wb_valid[i]),   64'(m_wb[i].v));
        chk("stall_cycles", i, stall_of(i),        64'(m_stall[i]));
        chk("flush_count",  i, flush_of(i),        64'(m_flush[i]));
    endtask

    task automatic advance(input int i, input int md);
        slot_t bub;
        bub = '{0, 0, 0, 0};
        if (md == 0) begin
            m_wb[i] = bub;
        end else begin
            m_wb[i]  = m_mem[i];
            m_mem[i] = m_ex[i];
            if (md == 3) m_ex[i] = '{id_valid, int'(id_rd), id_wen, id_is_load};
            else         m_ex[i] = bub;
        end
        if (md == 1) begin
            m_left[i] = 0;
            if (m_flush[i] < cap[i]) m_flush[i]++;
        end
        if (md == 2) begin
            if (m_left[i] > 0) m_left[i]--;
            else               m_left[i] = lu_tab[i] - 1;
        end
        if ((md == 0 || md == 2) && m_stall[i] < cap[i]) m_stall[i]++;
    endtask

    task automatic chk_reset();
        for (int i = 0; i < 2; i++) begin
            chk("rst_pc_en",    i, 64'(pc_en[i]),      64'd0);
            chk("rst_ifid_en",  i, 64'(ifid_en[i]),    64'd0);
            chk("rst_idex_en",  i, 64'(idex_en[i]),    64'd0);
            chk("rst_exmem_en", i, 64'(exmem_en[i]),   64'd0);
            chk("rst_memwb_en", i, 64'(memwb_en[i]),   64'd0);
            chk("rst_ifid_fl",  i, 64'(ifid_flush[i]), 64'd1);
            chk("rst_idex_fl",  i, 64'(idex_flush[i]), 64'd1);
            chk("rst_valids",   i, 64'({ex_valid[i], mem_valid[i], wb_valid[i]}), 64'd0);
            chk("rst_stall",    i, stall_of(i),        64'd0);
            chk("rst_flush",    i, flush_of(i),        64'd0);
        end
    endtask

    task automatic step(input bit v, input int rs1, input int rs2, input int rd,
                        input bit wen, input bit ld, input bit br, input bit busy);
        int md[2];
        @(negedge clk);
        id_valid        = v;
        id_rs1          = 5'(rs1);
        id_rs2          = 5'(rs2);
        id_rd           = 5'(rd);
        id_wen          = wen;
        id_is_load      = ld;
        ex_branch_taken = br;
        mem_busy        = busy;
        #1;
        for (int i = 0; i < 2; i++) begin
            md[i] = mode_of(i);
            compare(i, md[i]);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) advance(i, md[i]);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_wen = 0; id_is_load = 0; ex_branch_taken = 0; mem_busy = 0;
        reset_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_reset();
        @(posedge clk);
        #2 rst = 1'b0;

        // independent ALU ops
        for (int k = 0; k < 10; k++) step(1, 10 + k % 4, 20 + k % 4, k + 1, 1, 0, 0, 0);
        idle(3);

        // lw x5 ; add x6,x5,x1
        step(1, 1, 2, 5, 1, 1, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 5, 1, 6, 1, 0, 0, 0);
        idle(3);

        // same, with two memory-wait cycles inside the stall
        step(1, 1, 2, 5, 1, 1, 0, 0);
        step(1, 5, 1, 6, 1, 0, 0, 0);
        step(1, 5, 1, 6, 1, 0, 0, 0);
        step(1, 5, 1, 6, 1, 0, 0, 1);
        step(1, 5, 1, 6, 1, 0, 0, 1);
        for (int k = 0; k < 3; k++) step(1, 5, 1, 6, 1, 0, 0, 0);
        idle(2);

        // taken branch coinciding with a load-use hit
        step(1, 1, 2, 7, 1, 1, 0, 0);
        step(1, 7, 3, 8, 1, 0, 1, 0);
        idle(2);

        // load to x0 never interlocks
        step(1, 1, 2, 0, 1, 1, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0, 0);
        idle(2);

        // async reset in the middle of a load-use stall
        step(1, 1, 2, 5, 1, 1, 0, 0);
        step(1, 5, 1, 6, 1, 0, 0, 0);
        step(1, 5, 1, 6, 1, 0, 0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        reset_model();
        step(1, 5, 1, 6, 1, 0, 0, 0);
        idle(2);

        // random traffic over a small register range
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 2);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
